// File: rtl/rf_pkg.sv
// Shared widths, flag bit positions and limits for the ALU register file.
// Pure declarations: no logic, no latency, no flow control.
package rf_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int FLAG_COUNT = 4;
    localparam int FLAG_C     = 0;
    localparam int FLAG_N     = 1;
    localparam int FLAG_V     = 2;
    localparam int FLAG_Z     = 3;

    localparam int WRITE_COUNT_MAX = 255;

endpackage

// File: rtl/alu_status_flags.sv
// Four-bit ALU condition-flag register with load enable and synchronous reset.
// Latency: one cycle from load to output; always accepts, no backpressure.
module alu_status_flags
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [FLAG_COUNT-1:0] flags_i,
    output logic [FLAG_COUNT-1:0] flags_o
);

    logic [FLAG_COUNT-1:0] flags_q;
    logic [FLAG_COUNT-1:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (load_i) begin
            flags_d = flags_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/alu_register_file.sv
// ALU operand register file (r0 reads zero) with write bypass, flag register and write counter.
// Latency: reads combinational, writes/flags one cycle; always accepts, no backpressure.
module alu_register_file
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readAddrA,
    input  logic [ADDR_WIDTH-1:0] readAddrB,
    output logic [DATA_WIDTH-1:0] readDataA,
    output logic [DATA_WIDTH-1:0] readDataB,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  flagWriteEnable,
    input  logic                  carryIn,
    input  logic                  negativeIn,
    input  logic                  overFlowIn,
    input  logic                  zeroIn,
    output logic                  carryFlag,
    output logic                  negativeFlag,
    output logic                  overFlowFlag,
    output logic                  zeroFlag,
    output logic [7:0]            writeCount
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
    localparam logic [7:0] COUNT_MAX = 8'(WRITE_COUNT_MAX);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [7:0]            count_q;
    logic [7:0]            count_d;
    logic                  write_hit;
    logic [FLAG_COUNT-1:0] flags_in;
    logic [FLAG_COUNT-1:0] flags_out;

    // A write to r0 is treated as if it never happened: no storage, no bypass, no count.
    assign write_hit = writeEnable && (writeAddr != ZERO_ADDR);

    always_comb begin
        count_d = count_q;
        if (write_hit && (count_q != COUNT_MAX)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            if (write_hit) begin
                regs_q[writeAddr] <= writeData;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        readDataA = regs_q[readAddrA];
        if (readAddrA == ZERO_ADDR) begin
            readDataA = '0;
        end else if (BYPASS_EN && write_hit && (writeAddr == readAddrA)) begin
            readDataA = writeData;
        end
    end

    always_comb begin
        readDataB = regs_q[readAddrB];
        if (readAddrB == ZERO_ADDR) begin
            readDataB = '0;
        end else if (BYPASS_EN && write_hit && (writeAddr == readAddrB)) begin
            readDataB = writeData;
        end
    end

    always_comb begin
        flags_in         = '0;
        flags_in[FLAG_C] = carryIn;
        flags_in[FLAG_N] = negativeIn;
        flags_in[FLAG_V] = overFlowIn;
        flags_in[FLAG_Z] = zeroIn;
    end

    alu_status_flags u_flags (
        .clk     (clk),
        .reset   (reset),
        .load_i  (flagWriteEnable),
        .flags_i (flags_in),
        .flags_o (flags_out)
    );

    assign carryFlag    = flags_out[FLAG_C];
    assign negativeFlag = flags_out[FLAG_N];
    assign overFlowFlag = flags_out[FLAG_V];
    assign zeroFlag     = flags_out[FLAG_Z];
    assign writeCount   = count_q;

endmodule

// File: tb/tb_alu_register_file.sv
// Directed bench for alu_register_file: a bypassing and a non-bypassing instance share all inputs.
module tb_alu_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  readAddrA;
    logic [4:0]  readAddrB;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        flagWriteEnable;
    logic        carryIn, negativeIn, overFlowIn, zeroIn;

    logic [31:0] rdA, rdB, nb_rdA, nb_rdB;
    logic        cF, nF, vF, zF;
    logic        nb_cF, nb_nF, nb_vF, nb_zF;
    logic [7:0]  wcnt, nb_wcnt;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] model [32];

    alu_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .readAddrA(readAddrA), .readAddrB(readAddrB),
        .readDataA(rdA), .readDataB(rdB),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
        .flagWriteEnable(flagWriteEnable),
        .carryIn(carryIn), .negativeIn(negativeIn), .overFlowIn(overFlowIn), .zeroIn(zeroIn),
        .carryFlag(cF), .negativeFlag(nF), .overFlowFlag(vF), .zeroFlag(zF),
        .writeCount(wcnt)
    );

    alu_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .readAddrA(readAddrA), .readAddrB(readAddrB),
        .readDataA(nb_rdA), .readDataB(nb_rdB),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
        .flagWriteEnable(flagWriteEnable),
        .carryIn(carryIn), .negativeIn(negativeIn), .overFlowIn(overFlowIn), .zeroIn(zeroIn),
        .carryFlag(nb_cF), .negativeFlag(nb_nF), .overFlowFlag(nb_vF), .zeroFlag(nb_zF),
        .writeCount(nb_wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled near the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        readAddrA = '0; readAddrB = '0;
        writeEnable = 1'b0; writeAddr = '0; writeData = '0;
        flagWriteEnable = 1'b0;
        carryIn = 1'b0; negativeIn = 1'b0; overFlowIn = 1'b0; zeroIn = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        step();
        reset = 1'b0;

        // Reset state on every address, both ports, both instances.
        for (int a = 0; a < 32; a++) begin
            readAddrA = 5'(a);
            readAddrB = 5'(31 - a);
            #1;
            check($sformatf("reset_rdA_r%0d", a), rdA, 32'h0);
            check($sformatf("reset_rdB_r%0d", 31 - a), rdB, 32'h0);
            check($sformatf("reset_nb_rdA_r%0d", a), nb_rdA, 32'h0);
        end
        check("reset_flags", {28'h0, cF, nF, vF, zF}, 32'h0);
        check("reset_wcnt", {24'h0, wcnt}, 32'd0);

        // Write r5, read both ports next cycle.
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 5'd5; writeData = 32'hDEADBEEF;
        step();
        writeEnable = 1'b0;
        readAddrA = 5'd5; readAddrB = 5'd5;
        #1;
        check("r5_rdA", rdA, 32'hDEADBEEF);
        check("r5_rdB", rdB, 32'hDEADBEEF);
        check("r5_nb_rdA", nb_rdA, 32'hDEADBEEF);
        check("r5_wcnt", {24'h0, wcnt}, 32'd1);

        // Same-cycle bypass on port A only.
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 5'd7; writeData = 32'h12345678;
        readAddrA = 5'd7; readAddrB = 5'd5;
        #1;
        check("byp_r7_rdA", rdA, 32'h12345678);
        check("byp_r7_nb_rdA_old", nb_rdA, 32'h0);
        check("byp_r7_rdB_other", rdB, 32'hDEADBEEF);
        step();
        writeEnable = 1'b0;
        #1;
        check("r7_nb_rdA_after", nb_rdA, 32'h12345678);
        check("r7_wcnt", {24'h0, wcnt}, 32'd2);

        // Writes to r0 are discarded, including from the bypass path.
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 5'd0; writeData = 32'hFFFFFFFF;
        readAddrA = 5'd0; readAddrB = 5'd0;
        #1;
        check("r0_same_rdA", rdA, 32'h0);
        check("r0_same_rdB", rdB, 32'h0);
        check("r0_same_nb_rdA", nb_rdA, 32'h0);
        step();
        writeEnable = 1'b0;
        #1;
        check("r0_next_rdA", rdA, 32'h0);
        check("r0_next_rdB", rdB, 32'h0);
        check("r0_wcnt", {24'h0, wcnt}, 32'd2);

        // Port B bypass independently of port A.
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 5'd3; writeData = 32'hCAFEF00D;
        readAddrA = 5'd5; readAddrB = 5'd3;
        #1;
        check("byp_r3_rdB", rdB, 32'hCAFEF00D);
        check("byp_r3_rdA_other", rdA, 32'hDEADBEEF);
        check("byp_r3_nb_rdB_old", nb_rdB, 32'h0);
        step();
        writeEnable = 1'b0;
        #1;
        check("r3_wcnt", {24'h0, wcnt}, 32'd3);

        // Flag load C=1 N=0 V=1 Z=0 alongside a register write; no flag bypass.
        @(negedge clk);
        flagWriteEnable = 1'b1;
        carryIn = 1'b1; negativeIn = 1'b0; overFlowIn = 1'b1; zeroIn = 1'b0;
        writeEnable = 1'b1; writeAddr = 5'd10; writeData = 32'hA5A5A5A5;
        #1;
        check("flags_not_bypassed", {28'h0, cF, nF, vF, zF}, 32'h0);
        step();
        flagWriteEnable = 1'b0; writeEnable = 1'b0;
        carryIn = 1'b0; negativeIn = 1'b1; overFlowIn = 1'b0; zeroIn = 1'b1;
        readAddrA = 5'd10;
        #1;
        check("flags_loaded", {28'h0, cF, nF, vF, zF}, 32'hA);
        check("flags_nb_loaded", {28'h0, nb_cF, nb_nF, nb_vF, nb_zF}, 32'hA);
        check("r10_with_flags", rdA, 32'hA5A5A5A5);
        check("r10_wcnt", {24'h0, wcnt}, 32'd4);
        step();
        #1;
        check("flags_hold", {28'h0, cF, nF, vF, zF}, 32'hA);

        // 300 writes across r1..r31 drive the counter into saturation.
        model[5] = 32'hDEADBEEF; model[7] = 32'h12345678;
        model[3] = 32'hCAFEF00D; model[10] = 32'hA5A5A5A5;
        for (int i = 0; i < 300; i++) begin
            writeEnable = 1'b1;
            writeAddr   = 5'((i % 31) + 1);
            writeData   = 32'(i) * 32'h01010101 + 32'h00000007;
            model[(i % 31) + 1] = writeData;
            step();
            if (i == 99) begin
                #1;
                check("wcnt_after_100", {24'h0, wcnt}, 32'd104);
            end
        end
        writeEnable = 1'b0;
        #1;
        check("wcnt_saturated", {24'h0, wcnt}, 32'd255);
        check("nb_wcnt_saturated", {24'h0, nb_wcnt}, 32'd255);
        for (int a = 1; a < 32; a++) begin
            readAddrA = 5'(a);
            #1;
            check($sformatf("bulk_r%0d", a), rdA, model[a]);
        end
        step();
        #1;
        check("wcnt_holds", {24'h0, wcnt}, 32'd255);

        // Reset wins over a presented write and flag load.
        @(negedge clk);
        reset = 1'b1;
        writeEnable = 1'b1; writeAddr = 5'd9; writeData = 32'h99999999;
        flagWriteEnable = 1'b1;
        carryIn = 1'b1; negativeIn = 1'b1; overFlowIn = 1'b1; zeroIn = 1'b1;
        step();
        reset = 1'b0; writeEnable = 1'b0; flagWriteEnable = 1'b0;
        for (int a = 0; a < 32; a++) begin
            readAddrA = 5'(a);
            readAddrB = 5'(a);
            #1;
            check($sformatf("post_reset_r%0d", a), rdA, 32'h0);
        end
        readAddrB = 5'd9;
        #1;
        check("post_reset_r9_B", rdB, 32'h0);
        check("post_reset_nb_r9", nb_rdB, 32'h0);
        check("post_reset_flags", {28'h0, cF, nF, vF, zF}, 32'h0);
        check("post_reset_wcnt", {24'h0, wcnt}, 32'd0);

        // Normal operation resumes right after reset.
        @(negedge clk);
        writeEnable = 1'b1; writeAddr = 5'd9; writeData = 32'h0BADF00D;
        step();
        writeEnable = 1'b0;
        #1;
        check("resume_r9", rdB, 32'h0BADF00D);
        check("resume_wcnt", {24'h0, wcnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_register_file.md
Name: alu_register_file

Overview:
- 32-entry by 32-bit general-purpose register file plus a 4-bit condition-flag register.
- Sits directly upstream of the ALU: supplies both ALU operands (a, b) through two read ports.
- Takes back the ALU Result through one write port and the ALU carry/negative/overflow/zero flags through a flag-write port.
- Register 0 is hardwired to zero; same-cycle write-to-read bypass keeps back-to-back dependent ALU operations correct.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH.
- BYPASS_EN, 1, 1 forwards same-cycle write data to matching read ports; 0 returns the old stored value.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- readAddrA  input  ADDR_WIDTH  read port A address; drives ALU operand a.
- readAddrB  input  ADDR_WIDTH  read port B address; drives ALU operand b.
- readDataA  output  DATA_WIDTH  port A data, combinational.
- readDataB  output  DATA_WIDTH  port B data, combinational.
- writeEnable  input  1  write port enable.
- writeAddr  input  ADDR_WIDTH  write destination.
- writeData  input  DATA_WIDTH  write value (ALU Result).
- flagWriteEnable  input  1  capture the incoming flags this cycle.
- carryIn, negativeIn, overFlowIn, zeroIn  input  1 each  flags from the ALU.
- carryFlag, negativeFlag, overFlowFlag, zeroFlag  output  1 each  registered condition flags.
- writeCount  output  8  saturating count of committed non-zero-register writes since reset (debug/verification).

Behaviour:
- Reset (reset=1 at a rising clk edge):
  - all 32 registers go to 0;
  - all four flag outputs go to 0;
  - writeCount goes to 0.
  - Reset has priority over writeEnable and flagWriteEnable in the same cycle: no write is committed.
  - Before the first edge with reset high, state is undefined; verification must not check outputs then.
- Write:
  - When writeEnable=1 and writeAddr!=0, register[writeAddr] takes writeData at the edge.
  - Latency: 1 cycle; the stored value is visible through a normal read on the following cycle.
  - Writes to address 0 are discarded; register 0 always reads 0.
- Read:
  - Purely combinational from the addresses; zero cycles of latency.
  - Both ports may read the same address at the same time.
- Bypass (BYPASS_EN=1): if writeEnable=1, writeAddr!=0 and writeAddr equals a read address, that port outputs writeData in the same cycle. Each port is checked independently. Reads of address 0 always return 0, even while a write targets address 0.
- Flags:
  - When flagWriteEnable=1, all four flag outputs take the corresponding *In values at the edge, as one atomic update.
  - Otherwise the flags hold.
  - Flags are not bypassed; they are always one cycle behind the inputs.
- Simultaneous write and flag write in one cycle: both commit independently.
- writeCount:
  - Increments by 1 for each committed write to a non-zero register.
  - Saturates at 255 and does not wrap.
  - Writes to register 0 do not count.
- Reset asserted while a write is presented: the write is dropped and the state is fully cleared. Operation resumes on the first cycle after reset deasserts.
- No internal FSM beyond storage. All sequential logic sits in one clocked process gated by reset; read/bypass logic is combinational only.

Decomposition:
- Shared package (rf_pkg) holds:
  - DATA_WIDTH and ADDR_WIDTH defaults;
  - REG_ZERO = 5'd0;
  - flag bit indices FLAG_C=0, FLAG_N=1, FLAG_V=2, FLAG_Z=3;
  - WRITE_COUNT_MAX = 255.
- One sub-module is natural: alu_status_flags, a 4-bit flag register with synchronous reset and load enable, instantiated once.
- The storage array, bypass muxes and counter stay in the top module.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read returns 0; all flags 0; writeCount=0.
- Write 0xDEADBEEF to r5, next cycle read A=5, B=5 -> both return 0xDEADBEEF; writeCount=1.
- Write 0x12345678 to r7 while readAddrA=7 in the same cycle -> readDataA=0x12345678 in that cycle (BYPASS_EN=1), and the old value when BYPASS_EN=0.
- Write 0xFFFFFFFF to r0, then read r0 on both ports (same and next cycle) -> always 0; writeCount unchanged.
- Assert flagWriteEnable with C=1,N=0,V=1,Z=0, then change the inputs with the enable low -> flags read 1,0,1,0 from the next cycle and hold.
- Perform 300 writes to r1..r31, then assert reset while a write to r9 is presented -> writeCount reaches 255 and holds; after reset all registers, flags and writeCount are 0 and r9 is 0.
